// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph and symbol definitions for the display encoders
// and the receive-side decoder.
package seg7_pkg;

  // Segment order is {A,B,C,D,E,F,G} = seg[6:0]
  localparam logic [6:0] GLYPH_0     = 7'b1111110;
  localparam logic [6:0] GLYPH_1     = 7'b0110000;
  localparam logic [6:0] GLYPH_2     = 7'b1101101;
  localparam logic [6:0] GLYPH_3     = 7'b1111001;
  localparam logic [6:0] GLYPH_4     = 7'b0110011;
  localparam logic [6:0] GLYPH_5     = 7'b1011011;
  localparam logic [6:0] GLYPH_6     = 7'b1011111;
  localparam logic [6:0] GLYPH_7     = 7'b1110000;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1111011;
  localparam logic [6:0] GLYPH_AM    = 7'b1101111;
  localparam logic [6:0] GLYPH_PM    = 7'b1100111;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  localparam logic [3:0] SYM_AM      = 4'd10;
  localparam logic [3:0] SYM_PM      = 4'd11;
  localparam logic [3:0] SYM_BLANK   = 4'd12;
  localparam logic [3:0] SYM_INVALID = 4'd15;

  typedef enum logic {
    MER_AM = 1'b0,
    MER_PM = 1'b1
  } meridiem_e;

  // Forward mapping used by the encoder side; codes outside 0..12 show blank
  function automatic logic [6:0] sym_glyph(input logic [3:0] code);
    case (code)
      4'd0:    sym_glyph = GLYPH_0;
      4'd1:    sym_glyph = GLYPH_1;
      4'd2:    sym_glyph = GLYPH_2;
      4'd3:    sym_glyph = GLYPH_3;
      4'd4:    sym_glyph = GLYPH_4;
      4'd5:    sym_glyph = GLYPH_5;
      4'd6:    sym_glyph = GLYPH_6;
      4'd7:    sym_glyph = GLYPH_7;
      4'd8:    sym_glyph = GLYPH_8;
      4'd9:    sym_glyph = GLYPH_9;
      SYM_AM:  sym_glyph = GLYPH_AM;
      SYM_PM:  sym_glyph = GLYPH_PM;
      default: sym_glyph = GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_lut.sv
// Combinational reverse lookup: segment pattern to symbol code.
module seg7_glyph_lut
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  always_comb begin
    code = SYM_INVALID;
    case (seg)
      GLYPH_0:     code = 4'd0;
      GLYPH_1:     code = 4'd1;
      GLYPH_2:     code = 4'd2;
      GLYPH_3:     code = 4'd3;
      GLYPH_4:     code = 4'd4;
      GLYPH_5:     code = 4'd5;
      GLYPH_6:     code = 4'd6;
      GLYPH_7:     code = 4'd7;
      GLYPH_8:     code = 4'd8;
      GLYPH_9:     code = 4'd9;
      GLYPH_AM:    code = SYM_AM;
      GLYPH_PM:    code = SYM_PM;
      GLYPH_BLANK: code = SYM_BLANK;
      default:     code = SYM_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_meridiem_decoder.sv
// Seven-segment receive monitor: debounces the segment lines, classifies each
// stable glyph and tracks AM/PM state plus a saturating toggle count.
module seg7_meridiem_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [3:0] sym_code,
  output logic       sym_valid,
  output logic       sym_err,
  output logic       is_pm,
  output logic       meridiem_known,
  output logic [7:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [6:0]       cand;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             changed;
  logic             counting;
  logic             accept;
  logic [3:0]       code;
  logic             is_mer;
  meridiem_e        mer_new;

  // The candidate always becomes seg at the next edge, so classifying seg
  // directly gives the code of the run being accepted, even when
  // STABLE_CYCLES=1 accepts on the very edge of a change.
  seg7_glyph_lut u_lut (
    .seg  (seg),
    .code (code)
  );

  always_comb begin
    changed  = (seg != cand);
    counting = (stab_cnt < STABLE);
    cnt_nxt  = stab_cnt;
    if (changed)       cnt_nxt = CNT_W'(1);
    else if (counting) cnt_nxt = stab_cnt + CNT_W'(1);
    // A held run parks at STABLE, so only the edge that reaches it accepts
    accept  = (cnt_nxt == STABLE) && (changed || counting);
    is_mer  = (code == SYM_AM) || (code == SYM_PM);
    mer_new = (code == SYM_PM) ? MER_PM : MER_AM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand           <= GLYPH_BLANK;
      stab_cnt       <= '0;
      sym_code       <= SYM_BLANK;
      sym_valid      <= 1'b0;
      sym_err        <= 1'b0;
      is_pm          <= MER_AM;
      meridiem_known <= 1'b0;
      toggle_cnt     <= 8'd0;
    end else begin
      cand      <= seg;
      stab_cnt  <= cnt_nxt;
      sym_valid <= accept;
      if (accept) begin
        sym_code <= code;
        sym_err  <= (code == SYM_INVALID);
        if (is_mer) begin
          if (meridiem_known && (is_pm != mer_new) && (toggle_cnt != 8'hFF))
            toggle_cnt <= toggle_cnt + 8'd1;
          is_pm          <= mer_new;
          meridiem_known <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_meridiem_decoder.sv
// Randomised and directed checks of seg7_meridiem_decoder against a
// history-based reference model (STABLE_CYCLES=4) plus a STABLE_CYCLES=1 instance.
module tb_seg7_meridiem_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg, seg1;
  logic [3:0] sym_code, sym_code1;
  logic       sym_valid, sym_err, is_pm, meridiem_known;
  logic       sym_valid1, sym_err1, is_pm1, meridiem_known1;
  logic [7:0] toggle_cnt, toggle_cnt1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seg7_meridiem_decoder #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .sym_code(sym_code), .sym_valid(sym_valid),
    .sym_err(sym_err), .is_pm(is_pm), .meridiem_known(meridiem_known), .toggle_cnt(toggle_cnt)
  );

  seg7_meridiem_decoder #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg(seg1), .sym_code(sym_code1), .sym_valid(sym_valid1),
    .sym_err(sym_err1), .is_pm(is_pm1), .meridiem_known(meridiem_known1), .toggle_cnt(toggle_cnt1)
  );

  localparam int S = 4;
  localparam logic [6:0] AM = 7'b1101111;
  localparam logic [6:0] PM = 7'b1100111;
  localparam logic [15:0] RST_VEC = {4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

  logic [6:0] digit_glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011};

  // Reference model: samples since reset, and the expected output values
  logic [6:0] hist [$];
  int   m_code, m_tog;
  bit   m_valid, m_err, m_pm, m_known;
  logic [15:0] exp_vec;
  wire  [15:0] obs_vec = {sym_code, sym_valid, sym_err, is_pm, meridiem_known, toggle_cnt};

  function automatic int ref_code(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (s == digit_glyph[d]) return d;
    if (s == AM) return 10;
    if (s == PM) return 11;
    if (s == 7'b0000000) return 12;
    return 15;
  endfunction

  // Drive one edge and advance the model; a run is accepted when the last
  // S samples agree and either nothing older exists or the one before differs.
  task automatic step(input logic r, input logic [6:0] s);
    bit acc;
    int n, c;
    rst_n = r;
    seg   = s;
    @(posedge clk);
    if (!r) begin
      hist.delete();
      m_code = 12; m_valid = 0; m_err = 0; m_pm = 0; m_known = 0; m_tog = 0;
    end else begin
      hist.push_back(s);
      if (hist.size() > 24) void'(hist.pop_front());
      n   = hist.size();
      acc = (n >= S);
      if (acc) for (int k = n - S; k < n; k++) if (hist[k] != s) acc = 0;
      if (acc && n > S && hist[n-S-1] == s) acc = 0;
      m_valid = acc;
      if (acc) begin
        c      = ref_code(s);
        m_code = c;
        m_err  = (c == 15);
        if (c == 10 || c == 11) begin
          if (m_known && ((c == 11) != m_pm) && m_tog < 255) m_tog++;
          m_pm    = (c == 11);
          m_known = 1;
        end
      end
    end
    exp_vec = {4'(m_code), m_valid, m_err, m_pm, m_known, 8'(m_tog)};
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 7'b1111111);
    step(1'b0, 7'b0000000);
    checks++;
    if (obs_vec !== RST_VEC) $display("FAIL reset: got %h want %h", obs_vec, RST_VEC);
    else passes++;
  endtask

  task automatic test_blank_hold;
    int pulses = 0, at = 0;
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 7'b0000000);
      if (sym_valid) begin pulses++; at = i; end
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL blank_hold e%0d: got %h want %h", i, obs_vec, exp_vec);
      else passes++;
    end
    checks++;
    if (pulses != 1 || at != 4 || sym_code !== 4'd12 || meridiem_known !== 1'b0)
      $display("FAIL blank_pulse: got pulses=%0d at=%0d code=%0d want 1 at 4 code 12", pulses, at, sym_code);
    else passes++;
  endtask

  task automatic test_meridiem;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, (i < 6) ? AM : PM);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL meridiem c%0d: got %h want %h", i, obs_vec, exp_vec);
      else passes++;
      if (i == 5) begin
        checks++;
        if (sym_code !== 4'd10 || is_pm !== 1'b0 || toggle_cnt !== 8'd0)
          $display("FAIL after_am: got code=%0d pm=%b tog=%0d want 10 0 0", sym_code, is_pm, toggle_cnt);
        else passes++;
      end
    end
    checks++;
    if (sym_code !== 4'd11 || is_pm !== 1'b1 || toggle_cnt !== 8'd1)
      $display("FAIL after_pm: got code=%0d pm=%b tog=%0d want 11 1 1", sym_code, is_pm, toggle_cnt);
    else passes++;
  endtask

  task automatic test_glitch;
    int pulses = 0;
    logic [6:0] pat [8] = '{PM, PM, PM, 7'b0110000, PM, PM, PM, PM};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[i]);
      if (sym_valid) pulses++;
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL glitch c%0d: got %h want %h", i, obs_vec, exp_vec);
      else passes++;
    end
    checks++;
    if (pulses != 1 || sym_valid !== 1'b1 || sym_code !== 4'd11)
      $display("FAIL glitch_pulse: got pulses=%0d last_valid=%b code=%0d want 1 1 11", pulses, sym_valid, sym_code);
    else passes++;
  endtask

  task automatic test_invalid;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i < 4) ? 7'b1010101 : 7'b1111011);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL invalid c%0d: got %h want %h", i, obs_vec, exp_vec);
      else passes++;
      if (i == 3) begin
        checks++;
        if (sym_code !== 4'd15 || sym_err !== 1'b1 || sym_valid !== 1'b1)
          $display("FAIL invalid_code: got code=%0d err=%b want 15 1", sym_code, sym_err);
        else passes++;
      end
    end
    checks++;
    if (sym_code !== 4'd9 || sym_err !== 1'b0 || is_pm !== 1'b1)
      $display("FAIL digit9: got code=%0d err=%b pm=%b want 9 0 1", sym_code, sym_err, is_pm);
    else passes++;
  endtask

  task automatic test_random;
    logic [6:0] s;
    int len;
    for (int r = 0; r < 200; r++) begin
      case ($urandom_range(0, 3))
        0:       s = digit_glyph[$urandom_range(0, 9)];
        1:       s = ($urandom_range(0, 1) != 0) ? AM : PM;
        2:       s = 7'b0000000;
        default: s = 7'($urandom_range(0, 127));
      endcase
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        step(1'b1, s);
        checks++;
        if (obs_vec !== exp_vec) $display("FAIL random r%0d c%0d: got %h want %h", r, i, obs_vec, exp_vec);
        else passes++;
      end
    end
  endtask

  task automatic test_changing;
    logic [15:0] held;
    held = obs_vec;
    for (int i = 0; i < 20; i++) step(1'b1, digit_glyph[i % 10]);
    checks++;
    if (obs_vec !== held) $display("FAIL changing_hold: got %h want %h", obs_vec, held);
    else passes++;
  endtask

  task automatic test_saturate;
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, r[0] ? PM : AM);
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL saturate r%0d: got %h want %h", r, obs_vec, exp_vec);
      else passes++;
    end
    checks++;
    if (toggle_cnt !== 8'd255 || is_pm !== 1'b1)
      $display("FAIL sat_final: got tog=%0d pm=%b want 255 1", toggle_cnt, is_pm);
    else passes++;
    step(1'b1, AM);
    step(1'b1, AM);
    step(1'b0, AM);
    checks++;
    if (obs_vec !== RST_VEC) $display("FAIL mid_reset: got %h want %h", obs_vec, RST_VEC);
    else passes++;
    for (int i = 0; i < 4; i++) step(1'b1, AM);
    checks++;
    if (obs_vec !== exp_vec || toggle_cnt !== 8'd0 || meridiem_known !== 1'b1)
      $display("FAIL post_reset_am: got %h want %h", obs_vec, exp_vec);
    else passes++;
  endtask

  task automatic test_fast_s1;
    for (int d = 0; d < 10; d++) begin
      seg1 = digit_glyph[d];
      step(1'b1, seg);
      checks++;
      if (sym_valid1 !== 1'b1 || sym_code1 !== 4'(d))
        $display("FAIL s1_digit d%0d: got valid=%b code=%0d want 1 %0d", d, sym_valid1, sym_code1, d);
      else passes++;
    end
    step(1'b1, seg);
    checks++;
    if (sym_valid1 !== 1'b0 || sym_code1 !== 4'd9)
      $display("FAIL s1_hold: got valid=%b code=%0d want 0 9", sym_valid1, sym_code1);
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    seg   = 7'b0000000;
    seg1  = 7'b0000000;
    test_reset;
    test_blank_hold;
    test_meridiem;
    test_glitch;
    test_invalid;
    test_random;
    test_changing;
    test_saturate;
    test_fast_s1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
